rate_window_meter: RTL

Downstream measurement stage for the 32-stage fractional rate multiplier. Consumes the multiplier's per-cycle pulse output `z`, its terminal-count flag `w` and the shared enable `x`. Counts `z` pulses across each full multiplier period, framed by consecutive rising edges of `w`. Delivers each completed period count through a small FIFO with a valid/ready handshake, so the programmed rate word `c_0..c_32` can be checked in-system.

---
 rtl/rate_window_meter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rate_window_meter.sv
// -----------------------------------------------------------------------------
// rate_window_meter
//
// Measurement stage behind the 32-stage fractional rate multiplier. It counts
// multiplier pulses (z) over each full multiplier period. A period is framed by
// consecutive rising edges of the terminal-count flag (w). Each completed
// period count is queued in a small FIFO and offered on a valid/ready port.
// This lets the programmed rate word be checked in-system.
//
// Parameters
//   CNT_W  width of the pulse accumulator / out_count (saturating)
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clock      in   single clock, rising edge
//   clear_n    in   synchronous active-low reset
//   x          in   multiplier enable; measurement runs only while high
//   z          in   multiplier pulse, sampled every cycle
//   w          in   multiplier terminal-count flag; rising edge = boundary
//   out_ready  in   consumer accepts the head entry
//   out_valid  out  FIFO non-empty
//   out_count  out  pulse count of the head window (registered)
//   out_sat    out  head window's count saturated (registered)
//   overflow   out  sticky: a completed window was dropped on a full FIFO
//   busy       out  FSM is measuring a window
// -----------------------------------------------------------------------------
module rate_window_meter #(
    parameter int CNT_W = 34,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             x,
    input  logic             z,
    input  logic             w,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             overflow,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = CNT_W + 1;
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             w_q, w_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    head_q, head_d;
    logic             overflow_q, overflow_d;

    // FIFO storage; no reset needed, the pointers define what is valid.
    logic [EW-1:0]    mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             rise;
    logic             push_req;
    logic [EW-1:0]    push_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic [PW-1:0]    occupancy;
    logic [AW-1:0]    rd_idx_next;

    assign rise      = w & ~w_q;
    assign push_data = {sat_q, acc_q};

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign rd_idx_next = rd_ptr_q[AW-1:0] + AW'(1);

    assign pop     = ~fifo_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_req & (~fifo_full | pop);

    // ------------------------------------------------------------------
    // Window FSM and accumulator
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        push_req = 1'b0;
        w_d      = w;

        case (state_q)
            ST_IDLE: begin
                if (x) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (!x) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    // The boundary cycle's pulse opens the new window.
                    state_d = ST_MEASURE;
                    acc_d   = CNT_W'(z);
                    sat_d   = 1'b0;
                end
            end

            ST_MEASURE: begin
                if (!x) begin
                    // Partial window is abandoned; acc is left as-is.
                    state_d = ST_IDLE;
                end else if (rise) begin
                    // Close the window with the count so far, then restart it
                    // with this cycle's pulse.
                    push_req = 1'b1;
                    acc_d    = CNT_W'(z);
                    sat_d    = 1'b0;
                end else if (z) begin
                    if (acc_q == ACC_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, registered head and overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = overflow_q | (push_req & fifo_full & ~pop);
        head_d     = head_q;

        if (push_ok && fifo_empty) begin
            // The first entry goes straight to the output register.
            head_d = push_data;
        end else if (pop) begin
            if (occupancy == PW'(1)) begin
                // The last entry leaves. Any entry pushed now becomes the head.
                head_d = push_ok ? push_data : '0;
            end else begin
                // The next entry is already in storage. With DEPTH >= 2 a
                // simultaneous write never targets this slot.
                head_d = mem_q[rd_idx_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            w_q        <= 1'b0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (clear_n && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all straight from registers
    // ------------------------------------------------------------------
    assign out_valid = ~fifo_empty;
    assign out_count = head_q[CNT_W-1:0];
    assign out_sat   = head_q[CNT_W];
    assign overflow  = overflow_q;
    assign busy      = (state_q == ST_MEASURE);

endmodule
